// File: rtl/data_tlul_host_pkg.sv
// Constants and helpers for the data-side TL-UL host.
// Contents:
//   TL-UL opcode constants (A and D channel)
//   size_off_t      : TL-UL size plus the low two address bits
//   be2size_offset  : maps core byte enables to size/offset
package data_tlul_host_pkg;

    localparam logic [2:0] PutFullData    = 3'd0;
    localparam logic [2:0] PutPartialData = 3'd1;
    localparam logic [2:0] Get            = 3'd4;
    localparam logic [2:0] AccessAck      = 3'd0;
    localparam logic [2:0] AccessAckData  = 3'd1;

    typedef struct packed {
        logic [1:0] size;
        logic [1:0] offset;
    } size_off_t;

    // Naturally aligned byte and half-word enables shrink the access;
    // anything irregular (gaps, or no byte at all) is sent as a full word
    // and the mask tells the device which lanes really matter.
    function automatic size_off_t be2size_offset(input logic [3:0] be);
        size_off_t r;
        r.size   = 2'd2;
        r.offset = 2'd0;
        case (be)
            4'b1111: begin r.size = 2'd2; r.offset = 2'd0; end
            4'b0011: begin r.size = 2'd1; r.offset = 2'd0; end
            4'b1100: begin r.size = 2'd1; r.offset = 2'd2; end
            4'b0001: begin r.size = 2'd0; r.offset = 2'd0; end
            4'b0010: begin r.size = 2'd0; r.offset = 2'd1; end
            4'b0100: begin r.size = 2'd0; r.offset = 2'd2; end
            4'b1000: begin r.size = 2'd0; r.offset = 2'd3; end
            default: begin r.size = 2'd2; r.offset = 2'd0; end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tlul_pkg.sv
// TL-UL bus types shared by hosts and devices on the crossbar.
// Contents:
//   tl_a_user_t / TL_A_USER_DEFAULT : A-channel user sideband and its idle value
//   tl_h2d_t                        : host-to-device A channel plus d_ready
//   tl_d2h_t                        : device-to-host D channel plus a_ready
package tlul_pkg;

    localparam int TL_AW   = 32;
    localparam int TL_DW   = 32;
    localparam int TL_AIW  = 8;
    localparam int TL_DIW  = 1;
    localparam int TL_SZW  = 2;
    localparam int TL_DBW  = TL_DW / 8;

    typedef struct packed {
        logic [4:0] rsvd;
        logic [3:0] instr_type;
    } tl_a_user_t;

    // Data-side traffic is never an instruction fetch, so instr_type idles at "false".
    localparam tl_a_user_t TL_A_USER_DEFAULT = '{rsvd: 5'd0, instr_type: 4'b1001};

    typedef struct packed {
        logic              a_valid;
        logic [2:0]        a_opcode;
        logic [2:0]        a_param;
        logic [TL_SZW-1:0] a_size;
        logic [TL_AIW-1:0] a_source;
        logic [TL_AW-1:0]  a_address;
        logic [TL_DBW-1:0] a_mask;
        logic [TL_DW-1:0]  a_data;
        tl_a_user_t        a_user;
        logic              d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic              d_valid;
        logic [2:0]        d_opcode;
        logic [2:0]        d_param;
        logic [TL_SZW-1:0] d_size;
        logic [TL_AIW-1:0] d_source;
        logic [TL_DIW-1:0] d_sink;
        logic [TL_DW-1:0]  d_data;
        logic              d_error;
        logic              a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/tlul_req_encode.sv
// Combinational encoder from a core load/store request to TL-UL A-channel fields.
// Ports:
//   we, be, addr, wdata : core request attributes (addr[1:0] ignored)
//   opcode, size        : TL-UL opcode and log2 size
//   address             : word address with byte offset derived from be
//   mask, data          : byte mask and write data (zero for loads)
module tlul_req_encode
    import data_tlul_host_pkg::*;
(
    input  logic        we,
    input  logic [3:0]  be,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [2:0]  opcode,
    output logic [1:0]  size,
    output logic [31:0] address,
    output logic [3:0]  mask,
    output logic [31:0] data
);

    size_off_t so;

    // The core only supplies word addresses; the low bits come from be.
    logic [1:0] unused_addr_lsb;
    assign unused_addr_lsb = addr[1:0];

    always_comb begin
        so      = be2size_offset(be);
        opcode  = Get;
        if (we) begin
            opcode = (be == 4'b1111) ? PutFullData : PutPartialData;
        end
        size    = so.size;
        address = {addr[31:2], so.offset};
        mask    = be;
        data    = we ? wdata : 32'd0;
    end

endmodule

// File: rtl/data_tlul_host.sv
// Data-side TL-UL host: bridges the core LSU req/gnt/rvalid interface onto a
// TL-UL host port, tracking up to MaxOutstanding in-flight requests and
// returning in-order responses.
// Ports:
//   clock, rst_ni                     : clock, async active-low reset
//   data_req_i/gnt_o/we_i/be_i/
//   addr_i/wdata_i                    : core request side
//   data_rvalid_o/rdata_o/err_o       : registered core response
//   tl_o / tl_i                       : TL-UL host port
//   proto_err_o                       : sticky unexpected/out-of-order response flag
module data_tlul_host
    import data_tlul_host_pkg::*;
#(
    parameter int MaxOutstanding = 2,
    parameter int SrcW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1
) (
    input  logic              clock,
    input  logic              rst_ni,
    input  logic              data_req_i,
    output logic              data_gnt_o,
    input  logic              data_we_i,
    input  logic [3:0]        data_be_i,
    input  logic [31:0]       data_addr_i,
    input  logic [31:0]       data_wdata_i,
    output logic              data_rvalid_o,
    output logic [31:0]       data_rdata_o,
    output logic              data_err_o,
    output tlul_pkg::tl_h2d_t tl_o,
    input  tlul_pkg::tl_d2h_t tl_i,
    output logic              proto_err_o
);

    localparam int              CntW    = $clog2(MaxOutstanding + 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(MaxOutstanding);
    localparam logic [SrcW-1:0] SrcLast = SrcW'(MaxOutstanding - 1);

    logic [CntW-1:0] outstanding_q;
    logic [SrcW-1:0] src_q;
    logic [SrcW-1:0] exp_q;
    logic            rvalid_q;
    logic [31:0]     rdata_q;
    logic            err_q;
    logic            proto_err_q;

    logic [2:0]  enc_opcode;
    logic [1:0]  enc_size;
    logic [31:0] enc_address;
    logic [3:0]  enc_mask;
    logic [31:0] enc_data;

    logic a_valid;
    logic gnt;
    logic have_out;
    logic d_take;
    logic src_match;

    // Response ordering fields that this host has no use for.
    logic unused_d_fields;
    assign unused_d_fields = ^{tl_i.d_opcode, tl_i.d_param, tl_i.d_size, tl_i.d_sink};

    function automatic logic [SrcW-1:0] wrap_inc(input logic [SrcW-1:0] v);
        return (v == SrcLast) ? '0 : v + SrcW'(1);
    endfunction

    tlul_req_encode u_encode (
        .we      (data_we_i),
        .be      (data_be_i),
        .addr    (data_addr_i),
        .wdata   (data_wdata_i),
        .opcode  (enc_opcode),
        .size    (enc_size),
        .address (enc_address),
        .mask    (enc_mask),
        .data    (enc_data)
    );

    // Full blocks a_valid outright so no request is offered that could never
    // be tracked; a response consumed this cycle frees a slot for the next.
    assign a_valid    = data_req_i & (outstanding_q != CntMax);
    assign gnt        = a_valid & tl_i.a_ready;
    assign data_gnt_o = gnt;

    // A beat with nothing outstanding is dropped; otherwise it is always
    // answered, with a source mismatch reported as an error.
    assign have_out  = (outstanding_q != '0);
    assign d_take    = tl_i.d_valid & have_out;
    assign src_match = (tl_i.d_source == tlul_pkg::TL_AIW'(exp_q));

    always_comb begin
        tl_o           = '0;
        tl_o.a_valid   = a_valid;
        tl_o.a_opcode  = enc_opcode;
        tl_o.a_param   = 3'd0;
        tl_o.a_size    = enc_size;
        tl_o.a_source  = tlul_pkg::TL_AIW'(src_q);
        tl_o.a_address = enc_address;
        tl_o.a_mask    = enc_mask;
        tl_o.a_data    = enc_data;
        tl_o.a_user    = tlul_pkg::TL_A_USER_DEFAULT;
        tl_o.d_ready   = 1'b1;
    end

    // Issue-side bookkeeping: rolling source and in-flight count.
    always_ff @(posedge clock or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding_q <= '0;
            src_q         <= '0;
        end else begin
            if (gnt) begin
                src_q <= wrap_inc(src_q);
            end
            case ({gnt, d_take})
                2'b10:   outstanding_q <= outstanding_q + CntW'(1);
                2'b01:   outstanding_q <= outstanding_q - CntW'(1);
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

    // Response side: expected source, registered core response and the
    // sticky protocol error.
    always_ff @(posedge clock or negedge rst_ni) begin
        if (!rst_ni) begin
            exp_q       <= '0;
            rvalid_q    <= 1'b0;
            rdata_q     <= 32'd0;
            err_q       <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            rvalid_q <= d_take;
            if (d_take) begin
                exp_q   <= wrap_inc(exp_q);
                rdata_q <= tl_i.d_data;
                err_q   <= tl_i.d_error | ~src_match;
            end
            if (tl_i.d_valid && (!have_out || !src_match)) begin
                proto_err_q <= 1'b1;
            end
        end
    end

    assign data_rvalid_o = rvalid_q;
    assign data_rdata_o  = rdata_q;
    assign data_err_o    = err_q;
    assign proto_err_o   = proto_err_q;

endmodule

// File: tb/tb_data_tlul_host.sv
// Directed self-checking bench for data_tlul_host with a response scoreboard.
// Expected responses are queued when a D beat is driven and compared when
// data_rvalid_o fires; A-channel and status outputs are checked inline.
module tb_data_tlul_host;
    import data_tlul_host_pkg::*;

    localparam int MaxOut = 2;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic              clock = 1'b0;
    logic              rst_ni = 1'b0;
    logic              data_req_i;
    logic              data_gnt_o;
    logic              data_we_i;
    logic [3:0]        data_be_i;
    logic [31:0]       data_addr_i;
    logic [31:0]       data_wdata_i;
    logic              data_rvalid_o;
    logic [31:0]       data_rdata_o;
    logic              data_err_o;
    tlul_pkg::tl_h2d_t tl_h2d;
    tlul_pkg::tl_d2h_t tl_d2h;
    logic              proto_err_o;

    int   n_asserts = 0;
    int   n_fail = 0;
    int   model_out = 0;
    int   model_src = 0;
    int   model_exp = 0;
    logic model_proto = 1'b0;
    exp_t sb_q[$];

    always #5 clock = ~clock;

    data_tlul_host #(.MaxOutstanding(MaxOut)) dut (
        .clock         (clock),
        .rst_ni        (rst_ni),
        .data_req_i    (data_req_i),
        .data_gnt_o    (data_gnt_o),
        .data_we_i     (data_we_i),
        .data_be_i     (data_be_i),
        .data_addr_i   (data_addr_i),
        .data_wdata_i  (data_wdata_i),
        .data_rvalid_o (data_rvalid_o),
        .data_rdata_o  (data_rdata_o),
        .data_err_o    (data_err_o),
        .tl_o          (tl_h2d),
        .tl_i          (tl_d2h),
        .proto_err_o   (proto_err_o)
    );

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_stimulus(input logic we, input logic [3:0] be,
                                  input logic [31:0] addr, input logic [31:0] wdata);
        data_req_i   = 1'b1;
        data_we_i    = we;
        data_be_i    = be;
        data_addr_i  = addr;
        data_wdata_i = wdata;
    endtask

    task automatic idle_req();
        data_req_i = 1'b0;
    endtask

    // Drives one D beat for the coming edge and predicts how the host treats it.
    task automatic d_beat(input logic [7:0] src, input logic [31:0] data, input logic derr);
        logic mism;
        tl_d2h.d_valid  = 1'b1;
        tl_d2h.d_opcode = AccessAckData;
        tl_d2h.d_source = src;
        tl_d2h.d_data   = data;
        tl_d2h.d_error  = derr;
        if (model_out > 0) begin
            mism = (src != 8'(model_exp));
            sb_q.push_back('{rdata: data, err: derr | mism});
            if (mism) model_proto = 1'b1;
            model_exp = (model_exp + 1) % MaxOut;
            model_out--;
        end else begin
            model_proto = 1'b1;
        end
    endtask

    task automatic d_idle();
        tl_d2h.d_valid = 1'b0;
        tl_d2h.d_error = 1'b0;
    endtask

    task automatic expect_grant(input string tag);
        check_output({tag, "_avalid"}, 32'(tl_h2d.a_valid), 32'd1);
        check_output({tag, "_gnt"}, 32'(data_gnt_o), 32'd1);
        check_output({tag, "_source"}, 32'(tl_h2d.a_source), 32'(model_src));
        model_src = (model_src + 1) % MaxOut;
        model_out++;
    endtask

    task automatic expect_block(input string tag);
        check_output({tag, "_avalid"}, 32'(tl_h2d.a_valid), 32'd0);
        check_output({tag, "_gnt"}, 32'(data_gnt_o), 32'd0);
    endtask

    // Scoreboard consumer: every response pulse must match the oldest prediction.
    always @(negedge clock) begin
        if (rst_ni && data_rvalid_o) begin
            if (sb_q.size() == 0) begin
                check_output("unexpected_rvalid", 32'(data_rvalid_o), 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_output("resp_rdata", data_rdata_o, e.rdata);
                check_output("resp_err", 32'(data_err_o), 32'(e.err));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        data_req_i   = 1'b0;
        data_we_i    = 1'b0;
        data_be_i    = 4'h0;
        data_addr_i  = 32'd0;
        data_wdata_i = 32'd0;
        tl_d2h       = '0;

        // Reset state
        #12;
        check_output("rst_rvalid", 32'(data_rvalid_o), 32'd0);
        check_output("rst_rdata", data_rdata_o, 32'd0);
        check_output("rst_err", 32'(data_err_o), 32'd0);
        check_output("rst_proto", 32'(proto_err_o), 32'd0);
        check_output("rst_avalid", 32'(tl_h2d.a_valid), 32'd0);
        @(negedge clock);
        rst_ni = 1'b1;
        tick();

        // Word store and its AccessAck
        $display("[TB] word store");
        tl_d2h.a_ready = 1'b1;
        apply_stimulus(1'b1, 4'hF, 32'h1000_0004, 32'hDEAD_BEEF);
        #1;
        check_output("ws_opcode", 32'(tl_h2d.a_opcode), 32'd0);
        check_output("ws_size", 32'(tl_h2d.a_size), 32'd2);
        check_output("ws_mask", 32'(tl_h2d.a_mask), 32'hF);
        check_output("ws_address", tl_h2d.a_address, 32'h1000_0004);
        check_output("ws_data", tl_h2d.a_data, 32'hDEAD_BEEF);
        check_output("ws_param", 32'(tl_h2d.a_param), 32'd0);
        check_output("ws_dready", 32'(tl_h2d.d_ready), 32'd1);
        expect_grant("ws");
        tick();
        idle_req();
        d_beat(8'd0, 32'd0, 1'b0);
        tick();
        d_idle();
        check_output("ws_proto", 32'(proto_err_o), 32'(model_proto));
        tick();

        // Byte / half-word encoding, no grants
        $display("[TB] encoding");
        tl_d2h.a_ready = 1'b0;
        apply_stimulus(1'b0, 4'b0100, 32'h2000_0000, 32'hFFFF_FFFF);
        #1;
        check_output("enc_lb_opcode", 32'(tl_h2d.a_opcode), 32'd4);
        check_output("enc_lb_size", 32'(tl_h2d.a_size), 32'd0);
        check_output("enc_lb_address", tl_h2d.a_address, 32'h2000_0002);
        check_output("enc_lb_data", tl_h2d.a_data, 32'd0);
        check_output("enc_lb_gnt", 32'(data_gnt_o), 32'd0);
        apply_stimulus(1'b1, 4'b1100, 32'h2000_0003, 32'hCAFE_F00D);
        #1;
        check_output("enc_sh_opcode", 32'(tl_h2d.a_opcode), 32'd1);
        check_output("enc_sh_size", 32'(tl_h2d.a_size), 32'd1);
        check_output("enc_sh_address", tl_h2d.a_address, 32'h2000_0002);
        check_output("enc_sh_mask", 32'(tl_h2d.a_mask), 32'hC);
        apply_stimulus(1'b0, 4'b0101, 32'h2000_0001, 32'd0);
        #1;
        check_output("enc_nc_size", 32'(tl_h2d.a_size), 32'd2);
        check_output("enc_nc_address", tl_h2d.a_address, 32'h2000_0000);
        check_output("enc_nc_mask", 32'(tl_h2d.a_mask), 32'h5);
        apply_stimulus(1'b1, 4'b1000, 32'h2000_0000, 32'h0000_0011);
        #1;
        check_output("enc_sb_opcode", 32'(tl_h2d.a_opcode), 32'd1);
        check_output("enc_sb_size", 32'(tl_h2d.a_size), 32'd0);
        check_output("enc_sb_address", tl_h2d.a_address, 32'h2000_0003);
        idle_req();
        tl_d2h.a_ready = 1'b1;

        // Backpressure when full
        $display("[TB] full");
        tick();
        apply_stimulus(1'b0, 4'hF, 32'h3000_0000, 32'd0);
        #1; expect_grant("full_g1");
        tick();
        apply_stimulus(1'b0, 4'hF, 32'h3000_0004, 32'd0);
        #1; expect_grant("full_g2");
        tick();
        apply_stimulus(1'b0, 4'hF, 32'h3000_0008, 32'd0);
        #1; expect_block("full_blk1");
        tick();
        #1; expect_block("full_blk2");
        tick();
        d_beat(8'(model_exp), 32'h1234_5678, 1'b0);
        #1; expect_block("full_blk3");
        tick();
        d_idle();
        #1; expect_grant("full_g3");
        tick();
        idle_req();
        d_beat(8'(model_exp), 32'hA5A5_0001, 1'b0);
        tick();
        d_beat(8'(model_exp), 32'hA5A5_0002, 1'b0);
        tick();
        d_idle();
        check_output("full_proto", 32'(proto_err_o), 32'(model_proto));
        tick();

        // Simultaneous grant and response keep the count steady
        $display("[TB] simultaneous");
        apply_stimulus(1'b0, 4'hF, 32'h4000_0000, 32'd0);
        #1; expect_grant("sim_g1");
        tick();
        apply_stimulus(1'b0, 4'hF, 32'h4000_0004, 32'd0);
        d_beat(8'(model_exp), 32'h0000_0101, 1'b0);
        #1; expect_grant("sim_g2");
        tick();
        apply_stimulus(1'b0, 4'hF, 32'h4000_0008, 32'd0);
        d_beat(8'(model_exp), 32'h0000_0202, 1'b0);
        #1; expect_grant("sim_g3");
        tick();
        d_idle();
        apply_stimulus(1'b0, 4'hF, 32'h4000_000C, 32'd0);
        #1; expect_grant("sim_g4");
        tick();
        apply_stimulus(1'b0, 4'hF, 32'h4000_0010, 32'd0);
        #1; expect_block("sim_blk");
        tick();
        idle_req();
        d_beat(8'(model_exp), 32'h0000_0303, 1'b0);
        tick();
        d_beat(8'(model_exp), 32'h0000_0404, 1'b0);
        tick();
        d_idle();
        check_output("sim_proto", 32'(proto_err_o), 32'(model_proto));
        tick();

        // Error responses
        $display("[TB] errors");
        apply_stimulus(1'b0, 4'hF, 32'h5000_0000, 32'd0);
        #1; expect_grant("err_g1");
        tick();
        idle_req();
        d_beat(8'(model_exp), 32'hBAD0_0001, 1'b1);
        tick();
        d_idle();
        tick();
        check_output("err_derr_proto", 32'(proto_err_o), 32'd0);
        apply_stimulus(1'b0, 4'hF, 32'h5000_0004, 32'd0);
        #1; expect_grant("err_g2");
        tick();
        idle_req();
        d_beat(8'(model_exp ^ 1), 32'hBAD0_0002, 1'b0);
        tick();
        d_idle();
        check_output("err_mism_proto", 32'(proto_err_o), 32'd1);
        tick();
        d_beat(8'd0, 32'h0000_0099, 1'b0);
        tick();
        d_idle();
        check_output("err_stray_rvalid", 32'(data_rvalid_o), 32'd0);
        tick();
        check_output("err_stray_proto", 32'(proto_err_o), 32'(model_proto));

        // Reset with two requests in flight
        $display("[TB] reset mid-transaction");
        apply_stimulus(1'b0, 4'hF, 32'h6000_0000, 32'd0);
        #1; expect_grant("rst_g1");
        tick();
        apply_stimulus(1'b0, 4'hF, 32'h6000_0004, 32'd0);
        #1; expect_grant("rst_g2");
        tick();
        idle_req();
        #1;
        rst_ni = 1'b0;
        #1;
        check_output("mid_rst_rvalid", 32'(data_rvalid_o), 32'd0);
        check_output("mid_rst_rdata", data_rdata_o, 32'd0);
        check_output("mid_rst_err", 32'(data_err_o), 32'd0);
        check_output("mid_rst_proto", 32'(proto_err_o), 32'd0);
        check_output("mid_rst_avalid", 32'(tl_h2d.a_valid), 32'd0);
        model_out   = 0;
        model_src   = 0;
        model_exp   = 0;
        model_proto = 1'b0;
        sb_q.delete();
        @(negedge clock);
        rst_ni = 1'b1;
        tick();
        d_beat(8'd0, 32'h0000_0077, 1'b0);
        tick();
        d_idle();
        check_output("post_rst_stray_rvalid", 32'(data_rvalid_o), 32'd0);
        check_output("post_rst_stray_proto", 32'(proto_err_o), 32'(model_proto));
        apply_stimulus(1'b1, 4'hF, 32'h7000_0000, 32'h0000_0055);
        #1; expect_grant("post_rst_g1");
        tick();
        idle_req();
        d_beat(8'(model_exp), 32'd0, 1'b0);
        tick();
        d_idle();
        tick();
        tick();

        check_output("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/data_tlul_host.md
# data_tlul_host

Converts the core's data-side load/store interface (req/gnt/rvalid) into a TL-UL host port. It sits between the core LSU and the crossbar, upstream of the DCCM TL-UL SRAM adapter. It generates TL-UL opcode, size, mask and source. It tracks up to `MaxOutstanding` in-flight transactions and returns in-order responses with error reporting.

## Interface
- `MaxOutstanding`, default 2: maximum in-flight A-channel requests not yet answered on D; legal range 1–8.
- `SrcW`, default `$clog2(MaxOutstanding)` (min 1): width of the rolling source ID; upper `a_source` bits are tied to 0.
- `clock` in 1: sole clock; all state on rising edge.
- `rst_ni` in 1: reset, asynchronous and active-low.
- `data_req_i` in 1: core request; held with stable attributes until granted.
- `data_gnt_o` out 1: request accepted this cycle.
- `data_we_i` in 1: 1 = store, 0 = load.
- `data_be_i` in 4: byte enables.
- `data_addr_i` in 32: word-aligned address; bits [1:0] are ignored.
- `data_wdata_i` in 32: store data.
- `data_rvalid_o` out 1: one-cycle response pulse.
- `data_rdata_o` out 32: load data, valid with `data_rvalid_o`.
- `data_err_o` out 1: response error, valid with `data_rvalid_o`.
- `tl_o` out `tlul_pkg::tl_h2d_t`: A-channel and `d_ready` to the crossbar.
- `tl_i` in `tlul_pkg::tl_d2h_t`: D-channel and `a_ready` from the crossbar.
- `proto_err_o` out 1: sticky flag for an unexpected or out-of-order D response; cleared only by reset.

## Operation
- **Request acceptance.** `a_valid = data_req_i & ~full`, where `full = (outstanding == MaxOutstanding)`. `data_gnt_o = a_valid & a_ready`.
- **Opcode.**
  - Load → Get (4).
  - Store with `be == 4'b1111` → PutFullData (0).
  - Any other store → PutPartialData (1).
- **Size and low address bits.** Derived from `be`:
  - `1111` → size 2, offset 0.
  - `0011` → size 1, offset 0.
  - `1100` → size 1, offset 2.
  - One-hot `be` → size 0, offset = index of the set bit.
  - Any other pattern (non-contiguous, or `0000`) → size 2, offset 0.
  - `a_address = {data_addr_i[31:2], offset}`.
- **Mask and data.** For stores, `a_mask = be` and `a_data = wdata`. For loads, `a_mask = be` and `a_data = 0`.
- **Unused fields.** `a_param = 0`. `a_user` carries `tlul_pkg` default values.
- **Source ID.** `a_source` = rolling issue counter `src_q`, incremented modulo `MaxOutstanding` on each grant.
- **D channel.** `d_ready` is tied to 1 (the core cannot stall responses).
  - A D beat is consumed when `d_valid`.
  - If `outstanding > 0` and `d_source == exp_q`: `data_rvalid_o = 1`, `rdata = d_data`, `err = d_error`. Then `exp_q` increments modulo `MaxOutstanding`.
  - If the source mismatches: `data_rvalid_o = 1`, `err = 1`, `proto_err_o` is set, and `exp_q` still advances.
  - If `outstanding == 0`: the beat is dropped (no rvalid) and `proto_err_o` is set.
- **Outstanding counter.** Increments on grant and decrements on a consumed matched-or-mismatched beat. A simultaneous grant and beat leaves it unchanged.

## Timing
- Reset values:
  - `outstanding`, `src_q`, `exp_q` = 0; `proto_err_o` = 0.
  - `data_rvalid_o` = 0, `data_rdata_o` = 0, `data_err_o` = 0.
  - `tl_o` has `a_valid = 0`.
- The A channel is combinational from the core inputs. Grant is in the same cycle as `a_ready`.
- The response path is registered. `data_rvalid_o`, `rdata` and `err` assert the cycle after the D beat. Load-to-use latency = crossbar + slave latency + 1.
- When full, `a_valid` is low until the cycle after a response is consumed. When a response is consumed in the same cycle as `full`, the next cycle may grant.
- A reset asserted mid-operation clears all state immediately. Responses to pre-reset requests are dropped and set `proto_err_o`.
- `data_rvalid_o` is a single-cycle pulse per consumed beat. Back-to-back D beats give back-to-back pulses.

## Structure
- Shared package `data_tlul_host_pkg` holds:
  - opcode constants: `Get`, `PutFullData`, `PutPartialData`, `AccessAck`, `AccessAckData`;
  - a `be2size_offset` function returning a `size_off_t` struct.
- Use `tlul_pkg` types directly.
- One natural sub-module: `tlul_req_encode`, combinational, mapping {we, be, addr, wdata} to A-channel fields.

## Test plan
- **Word store.** `be=1111`, `addr=0x1000_0004`, `wdata=0xDEADBEEF`, `a_ready=1` → same-cycle grant; A channel shows opcode 0, size 2, mask F, `address 0x1000_0004`, source 0. D beat AccessAck → `rvalid`, `err=0` the next cycle.
- **Byte and half-word encoding.**
  - Load `be=0100` → Get, size 0, `address[1:0]=2`.
  - Store `be=1100` → PutPartial, size 1, `address[1:0]=2`.
  - Load `be=0101` → size 2, offset 0.
- **Backpressure and full.** With `MaxOutstanding=2` and D held idle:
  - Two grants occur; the third request shows `a_valid=0` and `gnt=0`.
  - D beat with source 0 and `d_data=0x12345678` → `rdata=0x12345678` the next cycle; the third request is granted that cycle with source 0.
- **Simultaneous grant and response at `outstanding=1`.** Outstanding stays 1; sources issued 0,1,0 are matched in order.
- **Errors.**
  - `d_error=1` → `err=1`, `proto_err_o` stays 0.
  - `d_source=1` while 0 is expected → `err=1`, `proto_err_o=1` (sticky).
  - D beat with no outstanding → no rvalid, `proto_err_o=1`.
- **Reset mid-transaction.** With 2 outstanding, pulse `rst_ni` low → all outputs zero asynchronously. A later stray D beat → dropped, `proto_err_o=1`.
